alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage block of the single-cycle 32-bit processor core.
- Contains three parts:
  - ALU-control decoder: aluop plus funct bits give a 3-bit ALU select.
  - 32-bit ALU producing a result and flags.
  - Two adders: PC+4, and branch target (PC+4 + offset<<2).
- Results and branch decision are registered, with one-cycle latency and a valid flag, feeding the writeback/PC-select logic.

Parameters:
- DW, 32, datapath width of operands, result and PC.
- PC_INC, 4, constant added to pc for the sequential address.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/controls valid this cycle.
- aluop  in  2  {aluop1,aluop0} from main control.
- funct  in  4  instruction bits [3:0].
- op_a  in  DW  first operand (register A).
- op_b  in  DW  second operand (register B or sign-extended immediate, already muxed).
- pc  in  DW  current program counter.
- ext_imm  in  DW  sign-extended 16-bit immediate.
- branch  in  1  beq-type branch.
- branch_ne  in  1  bne-type branch.
- out_valid  out  1  registered outputs valid.
- result  out  DW  registered ALU result.
- zout  out  1  registered zero flag.
- cout  out  1  registered carry/no-borrow flag.
- nout  out  1  registered sign flag.
- gout  out  3  registered ALU select actually used.
- pc_plus4  out  DW  registered pc+PC_INC.
- branch_tgt  out  DW  registered pc_plus4 + (ext_imm<<2).
- pcsrc  out  1  registered branch-taken decision.
- ovf  out  1  registered signed overflow (see Optional Feature).

Behaviour:
- Reset: while rst_n=0, all outputs are 0 asynchronously. The first capture is at the first rising edge after rst_n rises.
- Latency: inputs sampled at rising edge k appear on the outputs after edge k. No backpressure.
- out_valid <= in_valid every cycle. When in_valid=0, all data/flag outputs hold their previous values.
- ALU-control decode (combinational), gout codes:
  - aluop=00 -> 010 (ADD; lw/sw address).
  - aluop=01 -> 110 (SUB; beq/bne compare).
  - aluop=11 -> 001 (OR; ori).
  - aluop=10 (R-type), by funct:
    - 0000 -> 010 ADD
    - 0010 -> 110 SUB
    - 0100 -> 000 AND
    - 0101 -> 001 OR
    - 1010 -> 111 SLT
    - any other funct -> 010 ADD.
- ALU ops by gout:
  - 000: a&b.
  - 001: a|b.
  - 010: a+b; cout = carry out of bit DW-1.
  - 110: a-b, computed as a+~b+1; cout = carry out, so 1 means no borrow.
  - 111: result = 1 if signed a<b, else 0. Computed from the subtraction sign corrected by overflow.
  - 011, 100, 101: result 0, cout 0.
  - For AND, OR and SLT, cout = 0.
- Flags:
  - zout = (result==0).
  - nout = result[DW-1].
- Adders: arithmetic is modulo 2^DW, wrap silently.
  - pc_plus4 = pc + PC_INC.
  - branch_tgt = pc_plus4 + {ext_imm[DW-3:0],2'b00}.
- pcsrc = (branch & zero) | (branch_ne & ~zero), using the combinational zero of the same operation. If both branch and branch_ne are 1, pcsrc=1.
- No internal state other than the output registers.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: ovf is registered as signed overflow for ADD and SUB (operand signs versus result sign); 0 for all other ops.
- Undefined: ovf is constant 0 and no overflow logic is synthesised. The SLT correction is always present regardless of the macro.

Decomposition:
- Package alu_exec_pkg:
  - gout localparams: GOUT_AND, GOUT_OR, GOUT_ADD, GOUT_SUB, GOUT_SLT.
  - aluop codes.
  - funct codes.
  - DW default.
- One sub-module, alu_ctrl_dec: combinational aluop/funct -> gout.
- Instantiated once; the ALU and adders stay inline.

Test Plan:
- Reset: rst_n=0 mid-run with valid data -> all outputs 0 immediately; rst_n=1, in_valid=1, aluop=00, a=5, b=7 -> next edge result=12, gout=010, out_valid=1.
- R-type sweep: aluop=10, a=0x0000000F, b=0x00000003, funct 0000/0010/0100/0101/1010 -> result 0x12 / 0xC / 0x3 / 0xF / 0; then SLT with a=0xFFFFFFFF, b=1 -> 1.
- Branch: aluop=01, a=b=0x1234, branch=1, pc=0x10, ext_imm=0xFFFFFFFE -> zout=1, pcsrc=1, pc_plus4=0x14, branch_tgt=0x0C; same with branch_ne=1 only -> pcsrc=0.
- Carry/wrap: ADD 0xFFFFFFFF+1 -> result 0, zout=1, cout=1; pc=0xFFFFFFFC -> pc_plus4=0.
- Overflow (ALU_OVF_EN defined): ADD 0x7FFFFFFF+1 -> result 0x80000000, nout=1, ovf=1; without macro -> ovf=0.
- Hold: in_valid=0 after a valid op -> out_valid=0, result and flags unchanged; aluop=10, funct=1111 -> gout=010.

Source files
------------

// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_pkg
// Purpose  : Shared encodings for the execute stage: ALU select (gout) codes,
//            main-control aluop codes, R-type funct codes and the default
//            datapath width.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

  localparam int DW_DEFAULT = 32;

  // ALU select codes driven on gout
  localparam logic [2:0] GOUT_AND = 3'b000;
  localparam logic [2:0] GOUT_OR  = 3'b001;
  localparam logic [2:0] GOUT_ADD = 3'b010;
  localparam logic [2:0] GOUT_SUB = 3'b110;
  localparam logic [2:0] GOUT_SLT = 3'b111;

  // aluop codes from main control
  localparam logic [1:0] ALUOP_MEM   = 2'b00;  // lw/sw address add
  localparam logic [1:0] ALUOP_BR    = 2'b01;  // beq/bne compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode by funct
  localparam logic [1:0] ALUOP_ORI   = 2'b11;  // ori

  // R-type funct codes (instruction bits [3:0])
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_dec
// Purpose  : Combinational ALU-control decoder. Maps the main-control aluop
//            and the R-type funct field onto a 3-bit ALU select.
// Ports    : aluop [1:0] in  - {aluop1,aluop0} from main control
//            funct [3:0] in  - instruction bits [3:0]
//            gout  [2:0] out - ALU select
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
  import alu_exec_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output logic [2:0] gout
);

  always_comb begin
    gout = GOUT_ADD;
    case (aluop)
      ALUOP_MEM: gout = GOUT_ADD;
      ALUOP_BR:  gout = GOUT_SUB;
      ALUOP_ORI: gout = GOUT_OR;
      default: begin
        // R-type: unknown funct codes fall back to ADD
        case (funct)
          FUNCT_ADD: gout = GOUT_ADD;
          FUNCT_SUB: gout = GOUT_SUB;
          FUNCT_AND: gout = GOUT_AND;
          FUNCT_OR:  gout = GOUT_OR;
          FUNCT_SLT: gout = GOUT_SLT;
          default:   gout = GOUT_ADD;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute stage of the single-cycle core. Decodes the ALU select,
//            runs the 32-bit ALU, computes pc+PC_INC and the branch target,
//            and registers everything with one cycle of latency.
// Ports    : clk, rst_n (async, active low)
//            in_valid, aluop[1:0], funct[3:0], op_a, op_b, pc, ext_imm,
//            branch, branch_ne                                 - inputs
//            out_valid, result, zout, cout, nout, gout[2:0],
//            pc_plus4, branch_tgt, pcsrc, ovf                  - registered
// Config   : ALU_OVF_EN - when defined, ovf reports signed overflow of
//            ADD/SUB; otherwise ovf is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int PC_INC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [1:0]    aluop,
  input  logic [3:0]    funct,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] ext_imm,
  input  logic          branch,
  input  logic          branch_ne,
  output logic          out_valid,
  output logic [DW-1:0] result,
  output logic          zout,
  output logic          cout,
  output logic          nout,
  output logic [2:0]    gout,
  output logic [DW-1:0] pc_plus4,
  output logic [DW-1:0] branch_tgt,
  output logic          pcsrc,
  output logic          ovf
);

  localparam logic [DW-1:0] C_PC_INC = DW'(PC_INC);

  logic [2:0]    w_gout;
  logic          w_sub_mode;
  logic [DW-1:0] w_b_eff;
  logic [DW:0]   w_sum;
  logic          w_arith_ovf;
  logic [DW-1:0] w_result;
  logic          w_carry;
  logic          w_zero;
  logic [DW-1:0] w_pc_plus4;
  logic [DW-1:0] w_branch_tgt;
  logic          w_pcsrc;
  logic [1:0]    w_unused_imm_top;

  logic          r_out_valid;
  logic [DW-1:0] r_result;
  logic          r_zout;
  logic          r_cout;
  logic          r_nout;
  logic [2:0]    r_gout;
  logic [DW-1:0] r_pc_plus4;
  logic [DW-1:0] r_branch_tgt;
  logic          r_pcsrc;

  alu_ctrl_dec u_alu_ctrl_dec (
    .aluop (aluop),
    .funct (funct),
    .gout  (w_gout)
  );

  // One shared adder: SUB and SLT use a + ~b + 1
  assign w_sub_mode = (w_gout == GOUT_SUB) || (w_gout == GOUT_SLT);
  assign w_b_eff    = w_sub_mode ? ~op_b : op_b;
  assign w_sum      = {1'b0, op_a} + {1'b0, w_b_eff} + {{DW{1'b0}}, w_sub_mode};

  // Signed overflow of the shared adder: operands agree in sign, result does not.
  // Always needed to correct the SLT sign bit.
  assign w_arith_ovf = (op_a[DW-1] == w_b_eff[DW-1]) && (w_sum[DW-1] != op_a[DW-1]);

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (w_gout)
      GOUT_AND: w_result = op_a & op_b;
      GOUT_OR:  w_result = op_a | op_b;
      GOUT_ADD: begin
        w_result = w_sum[DW-1:0];
        w_carry  = w_sum[DW];
      end
      GOUT_SUB: begin
        w_result = w_sum[DW-1:0];
        w_carry  = w_sum[DW];
      end
      GOUT_SLT: w_result = {{(DW-1){1'b0}}, w_sum[DW-1] ^ w_arith_ovf};
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  assign w_zero       = (w_result == '0);
  assign w_pc_plus4   = pc + C_PC_INC;
  assign w_branch_tgt = w_pc_plus4 + {ext_imm[DW-3:0], 2'b00};
  assign w_pcsrc      = (branch & w_zero) | (branch_ne & ~w_zero);

  // Top immediate bits are shifted out of the branch offset
  assign w_unused_imm_top = ext_imm[DW-1:DW-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_zout       <= 1'b0;
      r_cout       <= 1'b0;
      r_nout       <= 1'b0;
      r_gout       <= 3'b000;
      r_pc_plus4   <= '0;
      r_branch_tgt <= '0;
      r_pcsrc      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result     <= w_result;
        r_zout       <= w_zero;
        r_cout       <= w_carry;
        r_nout       <= w_result[DW-1];
        r_gout       <= w_gout;
        r_pc_plus4   <= w_pc_plus4;
        r_branch_tgt <= w_branch_tgt;
        r_pcsrc      <= w_pcsrc;
      end
    end
  end

`ifdef ALU_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= ((w_gout == GOUT_ADD) || (w_gout == GOUT_SUB)) && w_arith_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zout       = r_zout;
  assign cout       = r_cout;
  assign nout       = r_nout;
  assign gout       = r_gout;
  assign pc_plus4   = r_pc_plus4;
  assign branch_tgt = r_branch_tgt;
  assign pcsrc      = r_pcsrc;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench for alu_exec_unit. Stimulus pushes expected
//            responses from a behavioural model into a queue; a monitor pops
//            and compares one entry per captured cycle.
// Config   : honours ALU_OVF_EN for the expected ovf value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        n;
    logic [2:0]  g;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        ps;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] op_a, op_b, pc, ext_imm;
  logic        branch, branch_ne;
  logic        out_valid, zout, cout, nout, pcsrc, ovf;
  logic [31:0] result, pc_plus4, branch_tgt;
  logic [2:0]  gout;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t held;
  exp_t m_e;

  alu_exec_unit #(.DW(32), .PC_INC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .aluop      (aluop),
    .funct      (funct),
    .op_a       (op_a),
    .op_b       (op_b),
    .pc         (pc),
    .ext_imm    (ext_imm),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .out_valid  (out_valid),
    .result     (result),
    .zout       (zout),
    .cout       (cout),
    .nout       (nout),
    .gout       (gout),
    .pc_plus4   (pc_plus4),
    .branch_tgt (branch_tgt),
    .pcsrc      (pcsrc),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: straight from the operation table, using wide/signed math
  function automatic exp_t model(input logic [1:0] op, input logic [3:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] imm,
                                 input logic br, input logic bne);
    exp_t        e;
    longint      sa, sb, sr;
    logic [32:0] wide;
    logic        ov;
    e  = '0;
    ov = 1'b0;
    e.v = 1'b1;
    case (op)
      2'b00: e.g = 3'b010;
      2'b01: e.g = 3'b110;
      2'b11: e.g = 3'b001;
      default: begin
        case (f)
          4'b0000: e.g = 3'b010;
          4'b0010: e.g = 3'b110;
          4'b0100: e.g = 3'b000;
          4'b0101: e.g = 3'b001;
          4'b1010: e.g = 3'b111;
          default: e.g = 3'b010;
        endcase
      end
    endcase
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = 0;
    case (e.g)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[31:0];
        e.c   = wide[32];
        sr    = sa + sb;
        ov    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b110: begin
        e.res = a - b;
        e.c   = (a >= b);
        sr    = sa - sb;
        ov    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: e.res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    e.z   = (e.res == 32'd0);
    e.n   = e.res[31];
    e.pc4 = p + 32'd4;
    e.tgt = p + 32'd4 + imm * 32'd4;
    e.ps  = (br && e.z) || (bne && !e.z);
`ifdef ALU_OVF_EN
    e.ov  = ov;
`else
    e.ov  = 1'b0;
`endif
    return e;
  endfunction

  task automatic issue(input logic v, input logic [1:0] op, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] imm,
                       input logic br, input logic bne);
    exp_t e;
    @(negedge clk);
    in_valid = v; aluop = op; funct = f; op_a = a; op_b = b;
    pc = p; ext_imm = imm; branch = br; branch_ne = bne;
    if (v) begin
      e    = model(op, f, a, b, p, imm, br, bne);
      held = e;
    end else begin
      e   = held;
      e.v = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, {27'd0, zout, cout, nout, pcsrc, ovf}, 32'd0);
    check({tag, "_gout"}, {29'd0, gout}, 32'd0);
    check({tag, "_pc4"}, pc_plus4, 32'd0);
    check({tag, "_tgt"}, branch_tgt, 32'd0);
  endtask

  // Monitor: one popped entry per captured cycle, sampled just after the edge
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      m_e = q.pop_front();
      check("out_valid", {31'd0, out_valid}, {31'd0, m_e.v});
      check("result", result, m_e.res);
      check("zout", {31'd0, zout}, {31'd0, m_e.z});
      check("cout", {31'd0, cout}, {31'd0, m_e.c});
      check("nout", {31'd0, nout}, {31'd0, m_e.n});
      check("gout", {29'd0, gout}, {29'd0, m_e.g});
      check("pc_plus4", pc_plus4, m_e.pc4);
      check("branch_tgt", branch_tgt, m_e.tgt);
      check("pcsrc", {31'd0, pcsrc}, {31'd0, m_e.ps});
      check("ovf", {31'd0, ovf}, {31'd0, m_e.ov});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] fset [5];
    logic [1:0] r_op;
    logic [3:0] r_f;
    logic [31:0] r_a, r_b;
    fset[0] = 4'b0000; fset[1] = 4'b0010; fset[2] = 4'b0100;
    fset[3] = 4'b0101; fset[4] = 4'b1010;
    held = '0;
    rst_n = 1'b0; in_valid = 1'b0; aluop = 2'b00; funct = 4'b0000;
    op_a = '0; op_b = '0; pc = '0; ext_imm = '0; branch = 1'b0; branch_ne = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 5+7
    issue(1, 2'b00, 4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 0, 0);
    // R-type sweep
    issue(1, 2'b10, 4'b0000, 32'hF, 32'h3, 32'h100, 32'h1, 0, 0);
    issue(1, 2'b10, 4'b0010, 32'hF, 32'h3, 32'h104, 32'h2, 0, 0);
    issue(1, 2'b10, 4'b0100, 32'hF, 32'h3, 32'h108, 32'h3, 0, 0);
    issue(1, 2'b10, 4'b0101, 32'hF, 32'h3, 32'h10C, 32'h4, 0, 0);
    issue(1, 2'b10, 4'b1010, 32'hF, 32'h3, 32'h110, 32'h5, 0, 0);
    issue(1, 2'b10, 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h114, 32'h6, 0, 0);
    // Branch taken / not taken, both asserted
    issue(1, 2'b01, 4'b0000, 32'h1234, 32'h1234, 32'h10, 32'hFFFFFFFE, 1, 0);
    issue(1, 2'b01, 4'b0000, 32'h1234, 32'h1234, 32'h10, 32'hFFFFFFFE, 0, 1);
    issue(1, 2'b01, 4'b0000, 32'h1234, 32'h1235, 32'h10, 32'hFFFFFFFE, 1, 1);
    // Carry / wrap
    issue(1, 2'b00, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFC, 32'h0, 0, 0);
    // Signed overflow on ADD and SUB
    issue(1, 2'b00, 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h20, 32'h0, 0, 0);
    issue(1, 2'b10, 4'b0010, 32'h80000000, 32'h1, 32'h24, 32'h0, 0, 0);
    // SLT with overflowed difference
    issue(1, 2'b10, 4'b1010, 32'h80000000, 32'h7FFFFFFF, 32'h28, 32'h0, 0, 0);
    // Hold, then unknown funct, then ori
    issue(0, 2'b11, 4'b0000, 32'hDEAD, 32'hBEEF, 32'h30, 32'h7, 1, 1);
    issue(0, 2'b00, 4'b0000, 32'h1, 32'h1, 32'h34, 32'h7, 0, 0);
    issue(1, 2'b10, 4'b1111, 32'h11, 32'h22, 32'h38, 32'h8, 0, 0);
    issue(1, 2'b11, 4'b1010, 32'hF0, 32'h0F, 32'h3C, 32'h9, 0, 1);
    drain();

    // Asynchronous reset in the middle of valid traffic
    @(negedge clk);
    in_valid = 1'b1; aluop = 2'b00; op_a = 32'h33; op_b = 32'h44; pc = 32'h80;
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    held = '0;
    rst_n = 1'b1;
    issue(1, 2'b00, 4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f  = ($urandom_range(0, 7) < 6) ? fset[$urandom_range(0, 4)] : 4'($urandom);
      case ($urandom_range(0, 3))
        0:       r_a = 32'($urandom_range(0, 15));
        1:       r_a = {1'b0, 31'($urandom)};
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       r_b = r_a;
        1:       r_b = 32'($urandom_range(0, 15));
        2:       r_b = 32'h80000000 ^ 32'($urandom_range(0, 3));
        default: r_b = $urandom;
      endcase
      issue($urandom_range(0, 4) != 0, r_op, r_f, r_a, r_b, $urandom, $urandom,
            1'($urandom), 1'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
